// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the fetch PC generator and its BTB.
package fetch_pkg;

  typedef logic [31:0] pc_t;

  localparam pc_t RESET_PC  = 32'h0000_0060;
  // Tag field is sized for the smallest BTB so any BTB_IDX fits; unused upper bits stay zero.
  localparam int  TAG_MAX_W = 30;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [29:0]          target;
  } btb_entry_t;

  function automatic int btb_entries(int btb_idx);
    return 1 << btb_idx;
  endfunction

  function automatic int btb_tag_w(int btb_idx);
    return 30 - btb_idx;
  endfunction

endpackage

// File: rtl/fetch_pc_gen_btb_array.sv
// Direct-mapped BTB storage: registered read with enable, write port with
// same-index bypass, valid bits cleared asynchronously by reset.
module btb_array
  import fetch_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output btb_entry_t       rd_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry
);

  localparam int ENTRIES = btb_entries(IDX_W);

  logic [ENTRIES-1:0]   valid_q;
  logic [TAG_MAX_W-1:0] tag_mem [ENTRIES];
  logic [29:0]          tgt_mem [ENTRIES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= wr_entry.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx] <= wr_entry.tag;
      tgt_mem[wr_idx] <= wr_entry.target;
    end
  end

  // A write landing on the index being read wins, so an update is seen by the fetch in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_entry <= '0;
    end else if (rd_en) begin
      if (wr_en && (wr_idx == rd_idx)) begin
        rd_entry <= wr_entry;
      end else begin
        rd_entry <= '{valid: valid_q[rd_idx], tag: tag_mem[rd_idx], target: tgt_mem[rd_idx]};
      end
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Two-slot fetch PC generator (F1 = pc_out, F2 = if_*) steered by BHT prediction
// plus an integrated BTB; EX redirects arriving under stall are held in a pending register.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int  BTB_IDX  = 6,
  parameter pc_t RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        prediction,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  output logic [31:0] pc_out,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        if_pred_taken,
  output logic [31:0] if_pred_target
);

  localparam int TAG_W = btb_tag_w(BTB_IDX);

  pc_t         pc_f2;
  logic        v_f2;
  logic        pend_q;
  logic [29:0] pend_pc_q;

  pc_t         pc_n;
  pc_t         pc_f2_n;
  logic        v_f2_n;
  logic        pend_n;
  logic [29:0] pend_pc_n;

  btb_entry_t  rd_entry;
  btb_entry_t  wr_entry;
  logic        kill;
  logic        btb_hit;
  logic        pred_taken;
  logic        unused_bits;

  btb_array #(.IDX_W(BTB_IDX)) u_btb (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (~stall),
    .rd_idx   (pc_out[BTB_IDX+1:2]),
    .rd_entry (rd_entry),
    .wr_en    (upd_valid),
    .wr_idx   (upd_pc[BTB_IDX+1:2]),
    .wr_entry (wr_entry)
  );

  assign wr_entry = '{valid: 1'b1, tag: TAG_MAX_W'(upd_pc[31 -: TAG_W]), target: upd_target[31:2]};

  assign kill       = redirect | pend_q;
  assign btb_hit    = rd_entry.valid && (rd_entry.tag == TAG_MAX_W'(pc_f2[31 -: TAG_W]));
  assign pred_taken = v_f2 & prediction & btb_hit & ~kill;

  assign if_pc          = pc_f2;
  assign if_valid       = v_f2 & ~kill;
  assign if_pred_taken  = pred_taken;
  assign if_pred_target = pred_taken ? {rd_entry.target, 2'b00} : 32'd0;

  assign unused_bits = ^{redirect_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  always_comb begin
    pc_n      = pc_out;
    pc_f2_n   = pc_f2;
    v_f2_n    = v_f2;
    pend_n    = pend_q;
    pend_pc_n = pend_pc_q;
    if (stall) begin
      if (redirect) begin
        pend_n    = 1'b1;
        pend_pc_n = redirect_pc[31:2];
      end
    end else begin
      pc_f2_n = pc_out;
      if (redirect) begin
        pc_n   = {redirect_pc[31:2], 2'b00};
        v_f2_n = 1'b0;
        pend_n = 1'b0;
      end else if (pend_q) begin
        pc_n   = {pend_pc_q, 2'b00};
        v_f2_n = 1'b0;
        pend_n = 1'b0;
      end else if (pred_taken) begin
        // The pc+4 fetch already issued becomes the single bubble.
        pc_n   = {rd_entry.target, 2'b00};
        v_f2_n = 1'b0;
      end else begin
        pc_n   = pc_out + 32'd4;
        v_f2_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out    <= {RESET_PC[31:2], 2'b00};
      pc_f2     <= '0;
      v_f2      <= 1'b0;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pc_out    <= pc_n;
      pc_f2     <= pc_f2_n;
      v_f2      <= v_f2_n;
      pend_q    <= pend_n;
      pend_pc_q <= pend_pc_n;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed table-driven bench for fetch_pc_gen plus a hand-written async reset sequence.
module tb_fetch_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        prediction;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic [31:0] pc_out;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;

  int total = 0;
  int bad   = 0;

  fetch_pc_gen dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .prediction     (prediction),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_target     (upd_target),
    .pc_out         (pc_out),
    .if_pc          (if_pc),
    .if_valid       (if_valid),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        pred;
    logic        redir;
    logic [31:0] rpc;
    logic        uv;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic [31:0] e_pc;
    logic        e_val;
    logic [31:0] e_ifpc;
    logic        e_pt;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vecs[$];
  vec_t rvecs[$];

  function automatic vec_t mk(logic s, logic p, logic r, logic [31:0] rpc,
                              logic uv, logic [31:0] upc, logic [31:0] utgt,
                              logic [31:0] e_pc, logic e_val, logic [31:0] e_ifpc,
                              logic e_pt, logic [31:0] e_tgt);
    vec_t v;
    v.stall = s;   v.pred = p;     v.redir = r;     v.rpc = rpc;
    v.uv = uv;     v.upc = upc;    v.utgt = utgt;
    v.e_pc = e_pc; v.e_val = e_val; v.e_ifpc = e_ifpc; v.e_pt = e_pt; v.e_tgt = e_tgt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Entered just after a rising edge; drives one cycle of inputs and checks that cycle's outputs.
  task automatic apply(input vec_t v, input string tag);
    stall       = v.stall;
    prediction  = v.pred;
    redirect    = v.redir;
    redirect_pc = v.rpc;
    upd_valid   = v.uv;
    upd_pc      = v.upc;
    upd_target  = v.utgt;
    @(negedge clk);
    chk({tag, " pc_out"}, pc_out, v.e_pc);
    chk({tag, " if_valid"}, {31'd0, if_valid}, {31'd0, v.e_val});
    if (v.e_val) chk({tag, " if_pc"}, if_pc, v.e_ifpc);
    chk({tag, " if_pred_taken"}, {31'd0, if_pred_taken}, {31'd0, v.e_pt});
    chk({tag, " if_pred_target"}, if_pred_target, v.e_tgt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // stall pred redir rpc  uv upc utgt | pc_out valid if_pc pt target
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h60,  0,0,       0,0));
    vecs.push_back(mk(0,1,0,0,           0,0,0,            32'h64,  1,32'h60,  0,0));
    vecs.push_back(mk(0,1,0,0,           1,32'h80,32'h200, 32'h68,  1,32'h64,  0,0));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h6C,  1,32'h68,  0,0));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h70,  1,32'h6C,  0,0));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h74,  1,32'h70,  0,0));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h78,  1,32'h74,  0,0));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h7C,  1,32'h78,  0,0));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h80,  1,32'h7C,  0,0));
    vecs.push_back(mk(0,1,0,0,           0,0,0,            32'h84,  1,32'h80,  1,32'h200));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h200, 0,0,       0,0));
    vecs.push_back(mk(0,0,1,32'h1083,    0,0,0,            32'h204, 0,0,       0,0));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h1080,0,0,       0,0));
    vecs.push_back(mk(0,1,0,0,           0,0,0,            32'h1084,1,32'h1080,0,0));
    vecs.push_back(mk(1,0,1,32'h300,     0,0,0,            32'h1088,0,0,       0,0));
    vecs.push_back(mk(1,0,0,0,           0,0,0,            32'h1088,0,0,       0,0));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h1088,0,0,       0,0));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h300, 0,0,       0,0));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h304, 1,32'h300, 0,0));
    vecs.push_back(mk(0,0,1,32'h80,      0,0,0,            32'h308, 0,0,       0,0));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h80,  0,0,       0,0));
    vecs.push_back(mk(0,1,1,32'h400,     0,0,0,            32'h84,  0,0,       0,0));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h400, 0,0,       0,0));
    vecs.push_back(mk(0,0,0,0,           1,32'h404,32'h503,32'h404, 1,32'h400, 0,0));
    vecs.push_back(mk(0,1,0,0,           0,0,0,            32'h408, 1,32'h404, 1,32'h500));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h500, 0,0,       0,0));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h504, 1,32'h500, 0,0));
    vecs.push_back(mk(0,0,1,32'hFFFF_FFFC,0,0,0,           32'h508, 0,0,       0,0));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'hFFFF_FFFC,0,0,  0,0));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h0,   1,32'hFFFF_FFFC,0,0));
    vecs.push_back(mk(0,0,0,0,           0,0,0,            32'h4,   1,32'h0,   0,0));

    // After mid-run reset: no pending redirect survives, BTB entry for 0x80 is gone.
    rvecs.push_back(mk(0,0,0,0,          0,0,0,            32'h60,  0,0,       0,0));
    rvecs.push_back(mk(0,0,0,0,          0,0,0,            32'h64,  1,32'h60,  0,0));
    rvecs.push_back(mk(0,0,1,32'h80,     0,0,0,            32'h68,  0,0,       0,0));
    rvecs.push_back(mk(0,0,0,0,          0,0,0,            32'h80,  0,0,       0,0));
    rvecs.push_back(mk(0,1,0,0,          0,0,0,            32'h84,  1,32'h80,  0,0));
    rvecs.push_back(mk(0,0,0,0,          0,0,0,            32'h88,  1,32'h84,  0,0));

    rst = 1'b1; stall = 1'b0; prediction = 1'b1; redirect = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset pc_out", pc_out, 32'h60);
    chk("reset if_pc", if_pc, 32'h0);
    chk("reset if_valid", {31'd0, if_valid}, 32'd0);
    chk("reset if_pred_taken", {31'd0, if_pred_taken}, 32'd0);
    chk("reset if_pred_target", if_pred_target, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

    // Leave a redirect pending under stall, then reset asynchronously between edges.
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h700; prediction = 1'b1;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    @(negedge clk);
    chk("stall hold pc_out", pc_out, 32'h8);
    chk("pending kill if_valid", {31'd0, if_valid}, 32'd0);
    rst = 1'b1;
    #1;
    chk("async reset pc_out", pc_out, 32'h60);
    chk("async reset if_pc", if_pc, 32'h0);
    chk("async reset if_valid", {31'd0, if_valid}, 32'd0);
    chk("async reset if_pred_target", if_pred_target, 32'h0);
    @(posedge clk);
    #1;
    stall = 1'b0;
    rst   = 1'b0;

    for (int i = 0; i < rvecs.size(); i++) apply(rvecs[i], $sformatf("r%0d", i));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage next-PC generator with an integrated branch target buffer (BTB). It owns the fetch PC and presents it to the instruction cache and the 2-bit BHT direction predictor. One cycle later it combines the BHT's taken/not-taken prediction with a BTB hit to steer fetch. It also accepts misprediction redirects and BTB updates from EX, and hands the fetched PC plus its prediction to IF/ID.

## Interface
- `BTB_IDX`, 6: log2 of BTB entries (64 entries).
- `RESET_PC`, 32'h0000_0060: fetch address after reset.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: hazard unit / icache miss; freezes all fetch state.
- `prediction` in 1: BHT taken bit for the `pc_out` presented in the previous cycle.
- `redirect` in 1: EX resolved a misprediction or jump.
- `redirect_pc` in 32: correct next PC; bits [1:0] ignored.
- `upd_valid` in 1: write BTB entry.
- `upd_pc` in 32: PC of the resolved taken branch or jump.
- `upd_target` in 32: its target; bits [1:0] ignored.
- `pc_out` out 32: F1 fetch address to icache and BHT `rindex` source.
- `if_pc` out 32: F2 PC to IF/ID.
- `if_valid` out 1: F2 slot holds a live instruction.
- `if_pred_taken` out 1: F2 instruction predicted taken.
- `if_pred_target` out 32: predicted target (0 when not taken).

## Operation
- Two-slot front end:
  - F1 holds `pc_out`.
  - F2 registers hold `pc_f2`, `v_f2`, and the BTB read result.
- BTB, direct-mapped, 2^BTB_IDX entries:
  - Index = pc[BTB_IDX+1:2].
  - Tag = pc[31:BTB_IDX+2].
  - Each entry stores {valid, tag, target[31:2]}.
  - Synchronous read at `pc_out` index.
  - Hit = valid and tag equal to `pc_f2` tag.
- `if_pred_taken` = `v_f2` & `prediction` & btb_hit & ~kill, where kill = `redirect` | pending.
- `if_valid` = `v_f2` & ~kill.
- Next-state priority, highest first:
  1. `rst`.
  2. Redirect:
     - If `redirect` and ~`stall`: `pc_out` <= {redirect_pc[31:2],2'b00}, `v_f2` <= 0.
     - If `redirect` and `stall`: latch into the pending register instead.
     - The first non-stall cycle with pending set applies it the same way and clears pending.
     - A newer `redirect` overwrites pending.
  3. `stall`: `pc_out`, F2 registers and BTB read register all hold.
  4. Predicted taken: `pc_out` <= target, `v_f2` <= 0. This squashes the pc+4 fetch already issued.
  5. Otherwise: `pc_f2` <= `pc_out`, `v_f2` <= 1, `pc_out` <= `pc_out`+4, wrapping modulo 2^32.
- BTB update:
  - `upd_valid` writes the entry on the clock edge regardless of `stall` or `redirect`.
  - If the read index equals the write index in the same cycle, the read returns the new data (write-through bypass).
- `pc_out`[1:0] is always 00.
- Reset values:
  - `pc_out`=RESET_PC.
  - `if_pc`=0, `if_valid`=0, `if_pred_taken`=0, `if_pred_target`=0.
  - pending=0.
  - All BTB valid bits = 0.

## Timing
- `pc_out` and all F2 state are registered.
- `if_valid`, `if_pred_taken` and `if_pred_target` are combinational from F2 registers plus the `prediction`/`redirect` inputs.
- BTB read latency is 1 cycle, matching the BHT's registered read.
- Predicted-taken branch costs exactly one bubble: the target appears on `pc_out` in the cycle after the branch occupies F2.
- Redirect latency is 1 cycle to `pc_out`. The F2 slot is killed in the same cycle `redirect` is asserted.
- A BTB update at cycle t is visible to a fetch whose F1 cycle is t or later.
- Asynchronous reset mid-operation:
  - Immediately forces reset values.
  - Drops pending.
  - Invalidates the BTB.

## Structure
- Shared package `fetch_pkg` holds:
  - `pc_t` (32-bit).
  - `RESET_PC`.
  - The `btb_entry_t` struct {valid, tag, target}.
  - Index/tag width functions of BTB_IDX.
- Sub-module `btb_array` contains the storage:
  - Synchronous read with read enable.
  - Write port with same-index bypass.
  - Asynchronous clear of valid bits.
- Next-PC mux, pending register and F2 registers live in `fetch_pc_gen`.

## Test plan
- Reset: assert `rst` mid-run → `pc_out`=0x60, `if_valid`=0; release → `pc_out` steps 0x60, 0x64, 0x68 with `if_pc` one cycle behind.
- Cold miss: `prediction`=1 and BTB empty → no redirect, `if_pred_taken`=0, sequential fetch continues.
- BTB update then hit:
  - Write upd_pc=0x80, upd_target=0x200.
  - Later F2 at 0x80 with `prediction`=1 → `if_pred_taken`=1, `if_pred_target`=0x200.
  - Next `pc_out`=0x200; the 0x84 slot arrives with `if_valid`=0.
- Aliasing: entry for 0x80 present, fetch 0x1080 (same index, different tag) with `prediction`=1 → no hit, sequential.
- Redirect under stall:
  - `stall`=1, `redirect` with 0x300 → `pc_out` holds.
  - Drop `stall` → next `pc_out`=0x300, no stale instruction valid.
  - Redirect plus same-cycle predicted-taken → redirect wins.
- Wrap and bypass:
  - `pc_out`=0xFFFF_FFFC → next 0x0000_0000.
  - BTB write and read to the same index in one cycle → new target returned.
